// File: rtl/nvram_upload_ctrl.sv
// CMOS NVRAM upload controller: tracks unsaved CPU writes to CMOS, requests an ioctl
// upload once the CPU has been quiet, and serves HPS byte reads from the CMOS read port.
module nvram_upload_ctrl #(
  parameter int          ADDR_W       = 10,
  parameter int          DATA_W       = 4,
  parameter logic [7:0]  UPLOAD_INDEX = 8'd4,
  parameter int          IDLE_TIMEOUT = 48_000_000
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              autosave_en,
  input  logic              cmos_we,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [16:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              ioctl_upload_req,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [DATA_W-1:0] ram_q,
  output logic              dirty
);

  localparam int               CNT_W      = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(IDLE_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  logic sel;
  logic sel_reg;
  logic sel_rise;
  logic sel_fall;

  assign sel      = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
  assign sel_rise = sel && !sel_reg;
  assign sel_fall = !sel && sel_reg;

  // ---------------------------------------------------------------------------
  // Dirty tracking and upload request
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             rearm_reg;
  logic             rearm_next;
  logic             dirty_next;
  logic             req_next;

  always_comb begin
    dirty_next = dirty;
    cnt_next   = cnt_reg;
    rearm_next = rearm_reg;

    if (cnt_reg != '0) begin
      cnt_next = cnt_reg - CNT_W'(1);
    end

    if (cmos_we) begin
      dirty_next = 1'b1;
      cnt_next   = CNT_RELOAD;
    end

    if (sel_fall) begin
      rearm_next = 1'b0;
      // A write landing on the falling edge still belongs to the session just ended.
      if (rearm_reg || cmos_we) begin
        cnt_next = CNT_RELOAD;
      end else begin
        dirty_next = 1'b0;
      end
    end else if (cmos_we && sel) begin
      rearm_next = 1'b1;
    end

    // Judged on next-cycle counter/dirty so the request lands the cycle the counter hits 0.
    req_next = autosave_en && !sel_rise &&
               (ioctl_upload_req || (dirty_next && (cnt_next == '0) && !sel));
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sel_reg          <= 1'b0;
      cnt_reg          <= '0;
      rearm_reg        <= 1'b0;
      dirty            <= 1'b0;
      ioctl_upload_req <= 1'b0;
    end else begin
      sel_reg          <= sel;
      cnt_reg          <= cnt_next;
      rearm_reg        <= rearm_next;
      dirty            <= dirty_next;
      ioctl_upload_req <= req_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------------
  state_t state_reg;
  state_t state_next;

  logic              accept;
  logic              addr_oor;
  logic              oor_reg;
  logic [DATA_W-1:0] data_reg;
  logic [7:0]        data_packed;

  assign accept      = (state_reg == S_IDLE) && ioctl_rd && sel;
  assign addr_oor    = (ioctl_addr >> ADDR_W) != 17'd0;
  assign data_packed = 8'(data_reg);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE:  if (accept) state_next = S_ISSUE;
      S_ISSUE: state_next = S_WAIT;
      S_WAIT:  state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  logic              ram_rd_next;
  logic [ADDR_W-1:0] ram_addr_next;
  logic              wait_next;
  logic [7:0]        din_next;

  always_comb begin
    ram_rd_next   = accept && !addr_oor;
    ram_addr_next = accept ? ioctl_addr[ADDR_W-1:0] : ram_addr;
    wait_next     = (state_next != S_IDLE);
    din_next      = ioctl_din;
    if (state_reg == S_DONE) begin
      din_next = oor_reg ? 8'hFF : data_packed;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ram_rd     <= 1'b0;
      ram_addr   <= '0;
      ioctl_wait <= 1'b0;
      ioctl_din  <= 8'h00;
      oor_reg    <= 1'b0;
      data_reg   <= '0;
    end else begin
      ram_rd     <= ram_rd_next;
      ram_addr   <= ram_addr_next;
      ioctl_wait <= wait_next;
      ioctl_din  <= din_next;
      if (accept) begin
        oor_reg <= addr_oor;
      end
      if (state_reg == S_WAIT) begin
        data_reg <= ram_q;
      end
    end
  end

endmodule

// File: tb/tb_nvram_upload_ctrl.sv
// Self-checking bench for nvram_upload_ctrl: table-driven reads, hand-written autosave,
// rearm and reset sequences, and a randomized phase against a timestamp-based model.
module tb_nvram_upload_ctrl;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        autosave_en;
  logic        cmos_we;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic        ioctl_rd;
  logic [16:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        ioctl_upload_req;
  logic [9:0]  ram_addr;
  logic        ram_rd;
  logic [3:0]  ram_q;
  logic        dirty;

  always #5 clk = ~clk;

  nvram_upload_ctrl #(
    .ADDR_W(10), .DATA_W(4), .UPLOAD_INDEX(8'd4), .IDLE_TIMEOUT(T)
  ) dut (
    .clk_sys(clk), .reset_n(reset_n), .autosave_en(autosave_en), .cmos_we(cmos_we),
    .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd),
    .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
    .ioctl_upload_req(ioctl_upload_req), .ram_addr(ram_addr), .ram_rd(ram_rd),
    .ram_q(ram_q), .dirty(dirty)
  );

  // CMOS RAM second read port: data one cycle after ram_rd
  logic [3:0] mem [1024];
  always @(posedge clk) begin
    if (ram_rd) ram_q <= mem[ram_addr];
  end

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: timestamps of the last counter reload and of the last accepted read
  int         m_reload;
  bit         m_dirty, m_rearm, m_req, m_sel_prev, m_oor;
  int         m_accept;
  logic [7:0] m_val, m_din;
  logic [9:0] m_ram_addr;
  bit         e_wait, e_ram_rd;

  task automatic model_reset();
    m_reload = -1; m_dirty = 0; m_rearm = 0; m_req = 0; m_sel_prev = 0;
    m_accept = -1; m_oor = 0; m_val = 8'h00; m_din = 8'h00; m_ram_addr = 10'd0;
    e_wait = 0; e_ram_rd = 0;
  endtask

  task automatic check_outputs();
    chk("dirty", dirty, m_dirty);
    chk("upload_req", ioctl_upload_req, m_req);
    chk("wait", ioctl_wait, e_wait);
    chk("ram_rd", ram_rd, e_ram_rd);
    chk("din", ioctl_din, m_din);
    chk("ram_addr", ram_addr, m_ram_addr);
  endtask

  // Drive one cycle of inputs (called at a negedge), advance, then compare at the next negedge
  task automatic step(input bit we, input bit ae, input bit up, input logic [7:0] idx,
                      input bit rd, input logic [16:0] addr);
    bit sel, rise, fall, quiet;
    cmos_we = we; autosave_en = ae; ioctl_upload = up; ioctl_index = idx;
    ioctl_rd = rd; ioctl_addr = addr;
    sel  = up && (idx == 8'd4);
    rise = sel && !m_sel_prev;
    fall = !sel && m_sel_prev;
    if (we) begin m_dirty = 1; m_reload = cyc; end
    if (fall) begin
      if (m_rearm || we) m_reload = cyc; else m_dirty = 0;
      m_rearm = 0;
    end else if (we && sel) begin
      m_rearm = 1;
    end
    quiet = (m_reload < 0) || ((cyc + 1 - m_reload) >= T + 1);
    m_req = ae && !rise && (m_req || (m_dirty && quiet && !sel));
    m_sel_prev = sel;
    if ((m_accept < 0 || cyc >= m_accept + 4) && rd && sel) begin
      m_accept   = cyc;
      m_oor      = addr >= 17'd1024;
      m_ram_addr = addr[9:0];
      m_val      = m_oor ? 8'hFF : {4'h0, mem[addr[9:0]]};
    end
    if (m_accept >= 0 && cyc + 1 == m_accept + 4) m_din = m_val;
    e_wait   = (m_accept >= 0) && (cyc + 1 > m_accept) && (cyc + 1 <= m_accept + 3);
    e_ram_rd = (m_accept >= 0) && (cyc + 1 == m_accept + 1) && !m_oor;
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask

  task automatic idle(input bit ae, input bit up);
    step(1'b0, ae, up, 8'd4, 1'b0, 17'd0);
  endtask

  typedef struct {
    logic [16:0] addr;
    logic [7:0]  idx;
    bit          respond;
    bit          rd_pulse;
    logic [7:0]  din;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, f, req_cyc, rd_cnt;
    bit r1;
    logic [2:0] wbits;
    bit up_r, ae_r;
    logic [7:0] idx_r;

    for (int i = 0; i < 1024; i++) mem[i] = 4'($urandom);
    mem[5] = 4'hA; mem[0] = 4'h3; mem[1023] = 4'h7;

    vecs[0] = '{17'h00005, 8'd4, 1'b1, 1'b1, 8'h0A};
    vecs[1] = '{17'h00400, 8'd4, 1'b1, 1'b0, 8'hFF};
    vecs[2] = '{17'h003FF, 8'd4, 1'b1, 1'b1, 8'h07};
    vecs[3] = '{17'h1FFFF, 8'd4, 1'b1, 1'b0, 8'hFF};
    vecs[4] = '{17'h00000, 8'd4, 1'b1, 1'b1, 8'h03};
    vecs[5] = '{17'h00005, 8'd0, 1'b0, 1'b0, 8'h03};

    // Reset state
    reset_n = 1'b0; autosave_en = 0; cmos_we = 0; ioctl_upload = 0;
    ioctl_index = 8'd0; ioctl_rd = 0; ioctl_addr = 17'd0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    cyc = 0;
    idle(1'b1, 1'b0);

    // Autosave: one write, request at +T+1, held, cleared one cycle after sel rises
    w = cyc;
    step(1'b1, 1'b1, 1'b0, 8'd4, 1'b0, 17'd0);
    chk("autosave_dirty_c1", dirty, 1'b1);
    req_cyc = -1;
    for (int i = 0; i < 60; i++) begin
      if (ioctl_upload_req === 1'b1) begin req_cyc = cyc; break; end
      idle(1'b1, 1'b0);
    end
    chk("autosave_req_cycle", req_cyc - w, T + 1);
    repeat (3) idle(1'b1, 1'b0);
    chk("autosave_req_hold", ioctl_upload_req, 1'b1);
    idle(1'b1, 1'b1);
    chk("autosave_req_clear", ioctl_upload_req, 1'b0);

    // Table-driven reads inside the session
    for (int v = 0; v < 6; v++) begin
      step(1'b0, 1'b1, 1'b1, vecs[v].idx, 1'b1, vecs[v].addr);
      r1 = ram_rd; rd_cnt = int'(ram_rd); wbits[0] = ioctl_wait;
      for (int k = 2; k <= 4; k++) begin
        step(1'b0, 1'b1, 1'b1, vecs[v].idx, 1'b0, 17'd0);
        rd_cnt += int'(ram_rd);
        if (k <= 3) wbits[k-1] = ioctl_wait;
      end
      chk($sformatf("vec%0d_ram_rd_c1", v), r1, vecs[v].rd_pulse);
      chk($sformatf("vec%0d_ram_rd_count", v), rd_cnt, vecs[v].rd_pulse ? 1 : 0);
      chk($sformatf("vec%0d_wait_c1_3", v), wbits, vecs[v].respond ? 3'b111 : 3'b000);
      chk($sformatf("vec%0d_wait_c4", v), ioctl_wait, 1'b0);
      chk($sformatf("vec%0d_din_c4", v), ioctl_din, vecs[v].din);
    end

    // Clean session: dirty, request, full 1024-byte upload, then session end clears dirty
    step(1'b1, 1'b1, 1'b0, 8'd4, 1'b0, 17'd0);
    repeat (T + 2) idle(1'b1, 1'b0);
    chk("clean_req_before", ioctl_upload_req, 1'b1);
    idle(1'b1, 1'b1);
    for (int a = 0; a < 1024; a++) begin
      step(1'b0, 1'b1, 1'b1, 8'd4, 1'b1, 17'(a));
      repeat (3) idle(1'b1, 1'b1);
      chk("upload_byte", ioctl_din, {4'h0, mem[a]});
    end
    idle(1'b1, 1'b0);
    chk("clean_dirty_cleared", dirty, 1'b0);
    repeat (2 * T) idle(1'b1, 1'b0);
    chk("clean_req_stays_0", ioctl_upload_req, 1'b0);

    // Rearm A: write mid-session
    idle(1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 8'd4, 1'b1, 17'd9);
    repeat (3) idle(1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 8'd4, 1'b0, 17'd0);
    repeat (4) idle(1'b1, 1'b1);
    f = cyc;
    idle(1'b1, 1'b0);
    chk("rearmA_dirty", dirty, 1'b1);
    req_cyc = -1;
    for (int i = 0; i < 60; i++) begin
      if (ioctl_upload_req === 1'b1) begin req_cyc = cyc; break; end
      idle(1'b1, 1'b0);
    end
    chk("rearmA_req_cycle", req_cyc - f, T + 1);

    // Rearm B: write exactly on the falling edge of sel, after a clean session
    idle(1'b1, 1'b1);
    repeat (3) idle(1'b1, 1'b1);
    idle(1'b1, 1'b0);
    chk("rearmB_clean_first", dirty, 1'b0);
    repeat (3) idle(1'b1, 1'b1);
    f = cyc;
    step(1'b1, 1'b1, 1'b0, 8'd4, 1'b0, 17'd0);
    chk("rearmB_dirty", dirty, 1'b1);
    req_cyc = -1;
    for (int i = 0; i < 60; i++) begin
      if (ioctl_upload_req === 1'b1) begin req_cyc = cyc; break; end
      idle(1'b1, 1'b0);
    end
    chk("rearmB_req_cycle", req_cyc - f, T + 1);
    idle(1'b0, 1'b0);
    chk("req_drop_on_autosave_off", ioctl_upload_req, 1'b0);

    // Randomized phase
    up_r = 0; ae_r = 1; idx_r = 8'd4;
    for (int i = 0; i < 3000; i++) begin
      logic [16:0] ra;
      if ($urandom_range(0, 39) == 0) up_r = !up_r;
      if ($urandom_range(0, 149) == 0) ae_r = !ae_r;
      if ($urandom_range(0, 59) == 0) idx_r = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'd4;
      ra = ($urandom_range(0, 9) == 0) ? 17'($urandom) : 17'($urandom_range(0, 2047));
      step($urandom_range(0, 24) == 0, ae_r, up_r, idx_r, $urandom_range(0, 2) == 0, ra);
    end

    // Reset asserted with the FSM in WAIT
    step(1'b1, 1'b1, 1'b0, 8'd4, 1'b0, 17'd0);
    idle(1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 8'd4, 1'b1, 17'd5);
    idle(1'b1, 1'b1);
    chk("pre_reset_wait", ioctl_wait, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    repeat (6) idle(1'b1, 1'b1);
    chk("post_reset_dirty", dirty, 1'b0);
    chk("post_reset_din", ioctl_din, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
